// File: rtl/spi_slave_shifter_pkg.sv
// ---------------------------------------------------------------------------
// spi_slave_shifter_pkg
// Shared definitions for the SPI responder data path: default character
// length, default synchronizer depth, FSM state encoding and the latched
// transfer-mode bundle.
// No ports (package).
// ---------------------------------------------------------------------------
package spi_slave_shifter_pkg;

    localparam int SLV_CHAR_LEN_DEF    = 8;
    localparam int SLV_SYNC_STAGES_DEF = 2;

    typedef enum logic {
        SLV_IDLE   = 1'b0,
        SLV_ACTIVE = 1'b1
    } slv_state_t;

    // Transfer mode, frozen for the duration of a selection.
    typedef struct packed {
        logic cpol;
        logic cpha;
        logic lsb_first;
    } slv_mode_t;

endpackage

// File: rtl/spi_slave_sync.sv
// ---------------------------------------------------------------------------
// spi_slave_sync
// Brings one asynchronous SPI pin into the wb_clk_in domain through a
// STAGES-deep synchronizer chain, followed by a registered edge detector.
// Ports:
//   wb_clk_in  in   system clock
//   wb_rst     in   asynchronous active-high reset
//   pin_in     in   asynchronous pin
//   level      out  synchronized level
//   rise/fall  out  one-cycle edge strobes, valid STAGES+1 cycles after
//                   the pin edge
// ---------------------------------------------------------------------------
module spi_slave_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic wb_clk_in,
    input  logic wb_rst,
    input  logic pin_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              level_d;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour and the chain really shifts.
    always_ff @(posedge wb_clk_in or posedge wb_rst) begin
        if (wb_rst) begin
            chain   <= {STAGES{RST_VAL}};
            level_d <= RST_VAL;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            chain   <= {chain[STAGES-2:0], pin_in};
            level_d <= chain[STAGES-1];
            rise    <= chain[STAGES-1] & ~level_d;
            fall    <= ~chain[STAGES-1] & level_d;
        end
    end

    assign level = chain[STAGES-1];

endmodule

// File: rtl/spi_slave_shifter.sv
// ---------------------------------------------------------------------------
// spi_slave_shifter
// SPI responder data path. SCLK/SS_N/MOSI are oversampled on wb_clk_in;
// fixed-length characters in all four CPOL/CPHA modes, either bit order.
// Ports:
//   wb_clk_in, wb_rst          system clock, async active-high reset
//   sclk_in, ss_n_in, mosi_in  SPI pins from the master (asynchronous)
//   miso_out, miso_oe          slave-out data and its output enable
//   cpol, cpha, lsb_first      transfer mode, sampled only while idle
//   tx_data, tx_load, tx_ready TX holding register write port
//   rx_data, rx_valid, rx_ack  received character handshake
//   overrun, underrun          one-cycle error pulses
//   busy                       high while selected
// ---------------------------------------------------------------------------
module spi_slave_shifter
    import spi_slave_shifter_pkg::*;
#(
    parameter int CHAR_LEN    = SLV_CHAR_LEN_DEF,
    parameter int SYNC_STAGES = SLV_SYNC_STAGES_DEF
) (
    input  logic                wb_clk_in,
    input  logic                wb_rst,
    input  logic                sclk_in,
    input  logic                ss_n_in,
    input  logic                mosi_in,
    output logic                miso_out,
    output logic                miso_oe,
    input  logic                cpol,
    input  logic                cpha,
    input  logic                lsb_first,
    input  logic [CHAR_LEN-1:0] tx_data,
    input  logic                tx_load,
    output logic                tx_ready,
    output logic [CHAR_LEN-1:0] rx_data,
    output logic                rx_valid,
    input  logic                rx_ack,
    output logic                overrun,
    output logic                underrun,
    output logic                busy
);

    localparam int               CNT_W    = $clog2(CHAR_LEN);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAR_LEN - 1);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic ss_n_lvl, ss_rise, ss_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;
    logic unused_sync;

    slv_state_t          state, state_nxt;
    slv_mode_t           mode_q, mode;
    logic [CNT_W-1:0]    bit_cnt;
    logic [CHAR_LEN-1:0] rx_sr, rx_next, tx_sr, tx_adv, tx_hold, reload_val;
    logic                reload_pend, skip_first;
    logic                active, start_evt, lead_stb, trail_stb;
    logic                sample_stb, shift_stb, char_done, do_reload;
    logic                miso_reload, miso_adv;

    spi_slave_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .wb_clk_in(wb_clk_in), .wb_rst(wb_rst), .pin_in(sclk_in),
        .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_slave_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss_n (
        .wb_clk_in(wb_clk_in), .wb_rst(wb_rst), .pin_in(ss_n_in),
        .level(ss_n_lvl), .rise(ss_rise), .fall(ss_fall)
    );

    spi_slave_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .wb_clk_in(wb_clk_in), .wb_rst(wb_rst), .pin_in(mosi_in),
        .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
    );

    // Only edges of SCLK/SS_N and the level of MOSI are consumed.
    assign unused_sync = &{1'b0, sclk_lvl, ss_n_lvl, mosi_rise, mosi_fall};

    // ---------------- FSM: state register ----------------
    always_ff @(posedge wb_clk_in or posedge wb_rst) begin
        if (wb_rst) state <= SLV_IDLE;
        else        state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    // NOTE: default assignment first so every path assigns state_nxt and no
    // latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            SLV_IDLE:   if (ss_fall) state_nxt = SLV_ACTIVE;
            SLV_ACTIVE: if (ss_rise) state_nxt = SLV_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        miso_oe = (state == SLV_ACTIVE);
        busy    = (state == SLV_ACTIVE);
    end

    // While idle the live mode pins are used, so the entry cycle already
    // sees the mode that gets frozen for the selection.
    assign mode = (state == SLV_IDLE) ? slv_mode_t'({cpol, cpha, lsb_first}) : mode_q;

    // Deselection wins over any SCLK strobe landing in the same cycle.
    assign active     = (state == SLV_ACTIVE) && !ss_rise;
    assign start_evt  = (state == SLV_IDLE) && ss_fall;
    assign lead_stb   = mode.cpol ? sclk_fall : sclk_rise;
    assign trail_stb  = mode.cpol ? sclk_rise : sclk_fall;
    assign sample_stb = active && (mode.cpha ? trail_stb : lead_stb);
    assign shift_stb  = active && (mode.cpha ? lead_stb : trail_stb);
    assign char_done  = sample_stb && (bit_cnt == LAST_BIT);

    assign rx_next = mode.lsb_first ? {mosi_lvl, rx_sr[CHAR_LEN-1:1]}
                                    : {rx_sr[CHAR_LEN-2:0], mosi_lvl};
    assign tx_adv  = mode.lsb_first ? (tx_sr >> 1) : (tx_sr << 1);

    // An empty holding register sends zeros.
    assign reload_val  = tx_ready ? '0 : tx_hold;
    assign do_reload   = start_evt || (shift_stb && reload_pend);
    assign miso_reload = mode.lsb_first ? reload_val[0] : reload_val[CHAR_LEN-1];
    assign miso_adv    = mode.lsb_first ? tx_adv[0]     : tx_adv[CHAR_LEN-1];

    // ---------------- data path ----------------
    always_ff @(posedge wb_clk_in or posedge wb_rst) begin
        if (wb_rst) begin
            mode_q      <= '0;
            bit_cnt     <= '0;
            rx_sr       <= '0;
            tx_sr       <= '0;
            tx_hold     <= '0;
            tx_ready    <= 1'b1;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            overrun     <= 1'b0;
            underrun    <= 1'b0;
            miso_out    <= 1'b0;
            reload_pend <= 1'b0;
            skip_first  <= 1'b0;
        end else begin
            overrun  <= 1'b0;
            underrun <= 1'b0;

            if (state == SLV_IDLE) mode_q <= mode;

            // TX side: a reload frees the holding register, and a coincident
            // tx_load refills it with the new value.
            if (do_reload) begin
                tx_sr    <= reload_val;
                miso_out <= miso_reload;
                underrun <= tx_ready;
                tx_ready <= !tx_load;
                if (tx_load) tx_hold <= tx_data;
            end else begin
                if (tx_load && tx_ready) begin
                    tx_hold  <= tx_data;
                    tx_ready <= 1'b0;
                end
                if (shift_stb) begin
                    // With cpha=1 the first leading edge only starts the
                    // character; bit 0 is already on MISO.
                    if (skip_first) begin
                        skip_first <= 1'b0;
                    end else begin
                        tx_sr    <= tx_adv;
                        miso_out <= miso_adv;
                    end
                end
            end

            // RX side and bit counter.
            if (start_evt) begin
                bit_cnt     <= '0;
                reload_pend <= 1'b0;
                skip_first  <= mode.cpha;
            end else if ((state == SLV_ACTIVE) && ss_rise) begin
                bit_cnt     <= '0;
                reload_pend <= 1'b0;
                skip_first  <= 1'b0;
                miso_out    <= 1'b0;
            end else begin
                if (shift_stb && reload_pend) reload_pend <= 1'b0;
                if (sample_stb) begin
                    rx_sr <= rx_next;
                    if (char_done) begin
                        bit_cnt     <= '0;
                        rx_data     <= rx_next;
                        reload_pend <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
            end

            if (char_done) begin
                rx_valid <= 1'b1;
                overrun  <= rx_valid && !rx_ack;
            end else if (rx_ack) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule
